// File: rtl/arm_shift_pipe_if.sv
// arm_shift_pipe_if: input-beat and result-beat handshake bundle for the operand-2 shifter
interface arm_shift_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic              in_imm;
  logic [7:0]        in_amt;
  logic [DATA_W-1:0] in_data;
  logic              in_carry;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_carry;
  logic [TAG_W-1:0]  out_tag;
  modport master (
    output in_valid, in_op, in_imm, in_amt, in_data, in_carry, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_tag
  );
  modport slave (
    input  in_valid, in_op, in_imm, in_amt, in_data, in_carry, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_tag
  );
endinterface

// File: rtl/arm_shift_pipe.sv
// arm_shift_pipe: pipelined ARMv7 barrel shifter (LSL/LSR/ASR/ROR/RRX) with ARM carry-out
module arm_shift_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 6
) (
  input logic             clk,
  input logic             rst_n,
  input logic             flush,
  arm_shift_pipe_if.slave bus
);
  localparam int              SH_W = $clog2(DATA_W);
  localparam logic [7:0]      W8   = 8'(DATA_W);
  localparam logic [SH_W:0]   WS   = (SH_W + 1)'(DATA_W);
  localparam logic [1:0]      OP_LSL = 2'd0;
  localparam logic [1:0]      OP_LSR = 2'd1;
  localparam logic [1:0]      OP_ASR = 2'd2;
  localparam logic [1:0]      OP_ROR = 2'd3;
  localparam logic [2:0]      C_PASS = 3'd0;
  localparam logic [2:0]      C_RRX  = 3'd1;
  localparam logic [2:0]      C_ZERO = 3'd2;
  localparam logic [2:0]      C_SIGN = 3'd3;
  localparam logic [2:0]      C_NORM = 3'd4;
  if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32 && DATA_W != 64) begin : g_bad_w
    $error("arm_shift_pipe: DATA_W must be 8, 16, 32 or 64");
  end
  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_lat
    $error("arm_shift_pipe: LATENCY must be 1 or 2");
  end
  // Normal shifts only ever see 1..W-1; every edge amount is folded into a fixed class beforehand.
  // Returns {carry, data}.
  function automatic logic [DATA_W:0] shift_fn(
    input logic [2:0]        cls,
    input logic [1:0]        op,
    input logic [SH_W-1:0]   a,
    input logic [DATA_W-1:0] d,
    input logic              fc,
    input logic              cin
  );
    logic [DATA_W:0]   lsl;
    logic [DATA_W:0]   lsr;
    logic [DATA_W:0]   asr;
    logic [DATA_W-1:0] rot;
    logic [DATA_W:0]   norm;
    lsl  = {1'b0, d} << a;
    lsr  = {d, 1'b0} >> a;
    asr  = $signed({d, 1'b0}) >>> a;
    rot  = (d >> a) | (d << (WS - {1'b0, a}));
    norm = (op == OP_LSL) ? lsl
         : (op == OP_LSR) ? {lsr[0], lsr[DATA_W:1]}
         : (op == OP_ASR) ? {asr[0], asr[DATA_W:1]}
         : {rot[DATA_W-1], rot};
    return (cls == C_PASS) ? {fc, d}
         : (cls == C_RRX)  ? {fc, cin, d[DATA_W-1:1]}
         : (cls == C_ZERO) ? {fc, {DATA_W{1'b0}}}
         : (cls == C_SIGN) ? {fc, {DATA_W{d[DATA_W-1]}}}
         : norm;
  endfunction
  logic              stall;
  logic              en;
  logic [SH_W-1:0]   amt_lo;
  logic              sgn;
  logic [2:0]        dec_cls;
  logic [SH_W-1:0]   dec_amt;
  logic              dec_fc;
  logic              s_valid;
  logic [2:0]        s_cls;
  logic [1:0]        s_op;
  logic [SH_W-1:0]   s_amt;
  logic [DATA_W-1:0] s_data;
  logic              s_fc;
  logic              s_cin;
  logic [TAG_W-1:0]  s_tag;
  logic [DATA_W:0]   res;
  logic              out_valid_q;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_carry_q;
  logic [TAG_W-1:0]  out_tag_q;
  assign stall  = out_valid_q & ~bus.out_ready;
  assign en     = ~stall;
  assign amt_lo = bus.in_amt[SH_W-1:0];
  assign sgn    = bus.in_data[DATA_W-1];
  // Fold every zero/edge/oversized amount into a fixed class with its carry; leave 1..W-1 as a normal shift
  always_comb begin
    dec_cls = C_NORM;
    dec_amt = amt_lo;
    dec_fc  = bus.in_carry;
    if (bus.in_imm) begin
      if (amt_lo == '0) begin
        dec_cls = (bus.in_op == OP_LSL) ? C_PASS : (bus.in_op == OP_ROR) ? C_RRX : (bus.in_op == OP_ASR) ? C_SIGN : C_ZERO;
        dec_fc  = (bus.in_op == OP_LSL) ? bus.in_carry : (bus.in_op == OP_ROR) ? bus.in_data[0] : sgn;
      end
    end else if (bus.in_amt == 8'd0) begin
      dec_cls = C_PASS;
    end else if (bus.in_op == OP_ROR) begin
      if (amt_lo == '0) begin
        dec_cls = C_PASS;
        dec_fc  = sgn;
      end
    end else if (bus.in_amt >= W8) begin
      dec_cls = (bus.in_op == OP_ASR) ? C_SIGN : C_ZERO;
      dec_fc  = (bus.in_amt != W8) ? ((bus.in_op == OP_ASR) ? sgn : 1'b0)
              : (bus.in_op == OP_LSL) ? bus.in_data[0] : sgn;
    end
  end
  if (LATENCY == 2) begin : g_two
    logic              s1_valid_q;
    logic              s1_valid_d;
    logic [2:0]        s1_cls_q;
    logic [1:0]        s1_op_q;
    logic [SH_W-1:0]   s1_amt_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              s1_fc_q;
    logic              s1_cin_q;
    logic [TAG_W-1:0]  s1_tag_q;
    assign s1_valid_d = flush ? 1'b0 : en ? bus.in_valid : s1_valid_q;
    // Stage 1: hold the decoded class, clamped amount and operand while the pipe is stalled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_cls_q   <= C_PASS;
        s1_op_q    <= '0;
        s1_amt_q   <= '0;
        s1_data_q  <= '0;
        s1_fc_q    <= 1'b0;
        s1_cin_q   <= 1'b0;
        s1_tag_q   <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        if (en) begin
          s1_cls_q  <= dec_cls;
          s1_op_q   <= bus.in_op;
          s1_amt_q  <= dec_amt;
          s1_data_q <= bus.in_data;
          s1_fc_q   <= dec_fc;
          s1_cin_q  <= bus.in_carry;
          s1_tag_q  <= bus.in_tag;
        end
      end
    end
    assign s_valid = s1_valid_q;
    assign s_cls   = s1_cls_q;
    assign s_op    = s1_op_q;
    assign s_amt   = s1_amt_q;
    assign s_data  = s1_data_q;
    assign s_fc    = s1_fc_q;
    assign s_cin   = s1_cin_q;
    assign s_tag   = s1_tag_q;
  end else begin : g_one
    assign s_valid = bus.in_valid;
    assign s_cls   = dec_cls;
    assign s_op    = bus.in_op;
    assign s_amt   = dec_amt;
    assign s_data  = bus.in_data;
    assign s_fc    = dec_fc;
    assign s_cin   = bus.in_carry;
    assign s_tag   = bus.in_tag;
  end
  assign res         = shift_fn(s_cls, s_op, s_amt, s_data, s_fc, s_cin);
  assign out_valid_d = flush ? 1'b0 : en ? s_valid : out_valid_q;
  // Result stage: flush clears the valid even under stall; payload only moves when the pipe advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (en) begin
        out_data_q  <= res[DATA_W-1:0];
        out_carry_q <= res[DATA_W];
        out_tag_q   <= s_tag;
      end
    end
  end
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_arm_shift_pipe.sv
// tb_arm_shift_pipe: directed vectors, pipeline corner cases and a multi-width random sweep
module tb_arm_shift_pipe;
  localparam int N  = 5;
  localparam int NV = 18;
  function automatic int cw(input int i);
    return (i == 1) ? 8 : (i == 2) ? 16 : (i >= 3) ? 64 : 32;
  endfunction
  function automatic int cl(input int i);
    return (i == 0 || i == 4) ? 2 : 1;
  endfunction
  typedef struct {
    logic [1:0]  op;
    logic        imm;
    logic [7:0]  amt;
    logic [63:0] d;
    logic        cin;
    logic [63:0] ed;
    logic        ec;
  } vec_t;
  typedef struct {
    logic [63:0] d;
    logic        c;
    logic [5:0]  t;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid[N];
  logic        s_imm[N];
  logic        s_cin[N];
  logic        s_oready[N];
  logic        s_flush[N];
  logic [1:0]  s_op[N];
  logic [7:0]  s_amt[N];
  logic [63:0] s_data[N];
  logic [5:0]  s_tag[N];
  logic        i_ready[N];
  logic        o_valid[N];
  logic        o_carry[N];
  logic [63:0] o_data[N];
  logic [5:0]  o_tag[N];
  int          errs = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : inst
    localparam int W = cw(g);
    arm_shift_pipe_if #(.DATA_W(W), .TAG_W(6)) ifc ();
    arm_shift_pipe #(.DATA_W(W), .LATENCY(cl(g)), .TAG_W(6)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(s_flush[g]),
      .bus(ifc.slave)
    );
    assign ifc.in_valid  = s_valid[g];
    assign ifc.in_op     = s_op[g];
    assign ifc.in_imm    = s_imm[g];
    assign ifc.in_amt    = s_amt[g];
    assign ifc.in_data   = s_data[g][W-1:0];
    assign ifc.in_carry  = s_cin[g];
    assign ifc.in_tag    = s_tag[g];
    assign ifc.out_ready = s_oready[g];
    assign i_ready[g]    = ifc.in_ready;
    assign o_valid[g]    = ifc.out_valid;
    assign o_data[g]     = 64'(ifc.out_data);
    assign o_carry[g]    = ifc.out_carry;
    assign o_tag[g]      = ifc.out_tag;
  end
  // Bit-by-bit reference of the ARM shifter rules; returns {carry, data}
  function automatic logic [64:0] ref_shift(input int w, input logic [1:0] op, input logic imm,
                                            input logic [7:0] amt, input logic [63:0] din, input logic cin);
    logic [63:0] d;
    logic [63:0] r;
    logic        c;
    logic        s;
    int          n;
    d = (w == 64) ? din : din & ((64'd1 << w) - 64'd1);
    s = d[w-1];
    n = imm ? int'(amt) % w : int'(amt);
    r = '0;
    if (imm && n == 0 && op != 2'd0) begin
      if (op == 2'd3) return {d[0], (d >> 1) | (64'(cin) << (w - 1))};
      n = w;
    end
    if (n == 0) return {cin, d};
    for (int i = 0; i < w; i++) begin
      case (op)
        2'd0:    r[i] = (i >= n) ? d[i-n] : 1'b0;
        2'd1:    r[i] = (i + n < w) ? d[i+n] : 1'b0;
        2'd2:    r[i] = (i + n < w) ? d[i+n] : s;
        default: r[i] = d[(i+n)%w];
      endcase
    end
    case (op)
      2'd0:    c = (n <= w) ? d[w-n] : 1'b0;
      2'd1:    c = (n <= w) ? d[n-1] : 1'b0;
      2'd2:    c = (n < w) ? d[n-1] : s;
      default: c = d[(n-1)%w];
    endcase
    return {c, r};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_all();
    for (int g = 0; g < N; g++) begin
      s_valid[g]  = 1'b0;
      s_oready[g] = 1'b1;
      s_flush[g]  = 1'b0;
    end
  endtask
  task automatic set_beat(input int g, input logic [1:0] op, input logic imm, input logic [7:0] amt,
                          input logic [63:0] d, input logic cin, input logic [5:0] tag);
    s_valid[g] = 1'b1;
    s_op[g]    = op;
    s_imm[g]   = imm;
    s_amt[g]   = amt;
    s_data[g]  = d;
    s_cin[g]   = cin;
    s_tag[g]   = tag;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    vec_t        tbl[NV];
    exp_t        q[$];
    exp_t        e;
    logic [5:0]  got[$];
    logic [64:0] m;
    logic        held;
    logic [63:0] sd;
    logic        sc;
    logic [5:0]  st;
    int          nxt;
    int          w;
    tbl[0]  = '{2'd0, 1'b0, 8'd4,   64'h1000_000F, 1'b0, 64'h0000_00F0, 1'b1};
    tbl[1]  = '{2'd0, 1'b0, 8'd32,  64'h0000_0001, 1'b0, 64'h0,         1'b1};
    tbl[2]  = '{2'd0, 1'b0, 8'd33,  64'h0000_0001, 1'b0, 64'h0,         1'b0};
    tbl[3]  = '{2'd2, 1'b1, 8'd0,   64'h8000_0001, 1'b0, 64'hFFFF_FFFF, 1'b1};
    tbl[4]  = '{2'd1, 1'b1, 8'd0,   64'h8000_0000, 1'b0, 64'h0,         1'b1};
    tbl[5]  = '{2'd3, 1'b1, 8'd0,   64'h0000_0003, 1'b1, 64'h8000_0001, 1'b1};
    tbl[6]  = '{2'd3, 1'b0, 8'd36,  64'h0000_00F1, 1'b0, 64'h1000_000F, 1'b0};
    tbl[7]  = '{2'd3, 1'b0, 8'd64,  64'h8000_1234, 1'b0, 64'h8000_1234, 1'b1};
    tbl[8]  = '{2'd1, 1'b0, 8'd0,   64'h1234_5678, 1'b1, 64'h1234_5678, 1'b1};
    tbl[9]  = '{2'd1, 1'b0, 8'd1,   64'h0000_0003, 1'b0, 64'h0000_0001, 1'b1};
    tbl[10] = '{2'd2, 1'b0, 8'd4,   64'h8000_0010, 1'b0, 64'hF800_0001, 1'b0};
    tbl[11] = '{2'd0, 1'b1, 8'd0,   64'h0000_ABCD, 1'b0, 64'h0000_ABCD, 1'b0};
    tbl[12] = '{2'd2, 1'b0, 8'd200, 64'h7FFF_FFFF, 1'b1, 64'h0,         1'b0};
    tbl[13] = '{2'd1, 1'b0, 8'd40,  64'h8000_0000, 1'b1, 64'h0,         1'b0};
    tbl[14] = '{2'd3, 1'b1, 8'd8,   64'h1234_5678, 1'b0, 64'h7812_3456, 1'b0};
    tbl[15] = '{2'd0, 1'b1, 8'd31,  64'h0000_0003, 1'b0, 64'h8000_0000, 1'b1};
    tbl[16] = '{2'd3, 1'b1, 8'd1,   64'h0000_0001, 1'b0, 64'h8000_0000, 1'b1};
    tbl[17] = '{2'd2, 1'b1, 8'd0,   64'h4000_0000, 1'b1, 64'h0,         1'b0};
    for (int g = 0; g < N; g++) begin
      s_op[g] = '0; s_imm[g] = 1'b0; s_amt[g] = '0; s_data[g] = '0; s_cin[g] = 1'b0; s_tag[g] = '0;
    end
    idle_all();
    rst_n = 1'b0;
    #12;
    for (int g = 0; g < N; g++) begin
      chk($sformatf("rst_valid%0d", g), 64'(o_valid[g]), 64'd0);
      chk($sformatf("rst_data%0d", g), o_data[g], 64'd0);
      chk($sformatf("rst_carry%0d", g), 64'(o_carry[g]), 64'd0);
      chk($sformatf("rst_tag%0d", g), 64'(o_tag[g]), 64'd0);
      chk($sformatf("rst_in_ready%0d", g), 64'(i_ready[g]), 64'd1);
    end
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < NV; i++) begin
      set_beat(0, tbl[i].op, tbl[i].imm, tbl[i].amt, tbl[i].d, tbl[i].cin, 6'(i + 1));
      tick();
      s_valid[0] = 1'b0;
      chk($sformatf("vec%0d_early", i), 64'(o_valid[0]), 64'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(o_valid[0]), 64'd1);
      chk($sformatf("vec%0d_data", i), o_data[0], tbl[i].ed);
      chk($sformatf("vec%0d_carry", i), 64'(o_carry[0]), 64'(tbl[i].ec));
      chk($sformatf("vec%0d_tag", i), 64'(o_tag[0]), 64'(i + 1));
    end
    tick();
    chk("vec_drained", 64'(o_valid[0]), 64'd0);
    set_beat(1, 2'd0, 1'b1, 8'd0, 64'h5A, 1'b0, 6'd7);
    tick();
    s_valid[1] = 1'b0;
    chk("lat1_valid", 64'(o_valid[1]), 64'd1);
    chk("lat1_data", o_data[1], 64'h5A);
    tick();
    chk("lat1_drained", 64'(o_valid[1]), 64'd0);
    got.delete();
    nxt = 1;
    for (int c = 0; c < 20; c++) begin
      set_beat(0, 2'd0, 1'b1, 8'd0, 64'(nxt), 1'b0, 6'(nxt));
      s_valid[0]  = (nxt <= 5);
      s_oready[0] = !(c >= 2 && c <= 4);
      @(negedge clk);
      if (c == 2) begin
        chk("bp_stall_valid", 64'(o_valid[0]), 64'd1);
        sd = o_data[0];
        st = o_tag[0];
      end
      if (c == 3) chk("bp_in_ready", 64'(i_ready[0]), 64'd0);
      if (c == 3 || c == 4) begin
        chk("bp_hold_data", o_data[0], sd);
        chk("bp_hold_tag", 64'(o_tag[0]), 64'(st));
      end
      if (o_valid[0] && s_oready[0]) got.push_back(o_tag[0]);
      if (s_valid[0] && i_ready[0]) nxt++;
      tick();
    end
    chk("bp_count", 64'(got.size()), 64'd5);
    for (int k = 0; k < 5; k++) if (k < got.size()) chk($sformatf("bp_order%0d", k), 64'(got[k]), 64'(k + 1));
    idle_all();
    tick();
    for (int c = 0; c < 3; c++) begin
      set_beat(0, 2'd0, 1'b1, 8'd0, 64'(10 + c), 1'b0, 6'(10 + c));
      s_flush[0] = (c == 2);
      @(negedge clk);
      if (c == 2) chk("fl_in_ready", 64'(i_ready[0]), 64'd1);
      tick();
    end
    s_valid[0] = 1'b0;
    s_flush[0] = 1'b0;
    chk("fl_valid_a", 64'(o_valid[0]), 64'd0);
    tick();
    chk("fl_valid_b", 64'(o_valid[0]), 64'd0);
    tick();
    chk("fl_valid_c", 64'(o_valid[0]), 64'd0);
    set_beat(0, 2'd0, 1'b1, 8'd0, 64'h20, 1'b0, 6'd20);
    tick();
    s_valid[0] = 1'b0;
    tick();
    chk("fl_after_valid", 64'(o_valid[0]), 64'd1);
    chk("fl_after_tag", 64'(o_tag[0]), 64'd20);
    tick();
    chk("fl_after_once", 64'(o_valid[0]), 64'd0);
    set_beat(0, 2'd0, 1'b1, 8'd0, 64'h30, 1'b0, 6'd30);
    tick();
    s_valid[0] = 1'b0;
    tick();
    s_oready[0] = 1'b0;
    s_flush[0]  = 1'b1;
    @(negedge clk);
    chk("flst_in_ready", 64'(i_ready[0]), 64'd0);
    tick();
    chk("flst_valid", 64'(o_valid[0]), 64'd0);
    idle_all();
    for (int c = 0; c < 3; c++) begin
      set_beat(0, 2'd0, 1'b1, 8'd0, 64'hFF, 1'b1, 6'(40 + c));
      tick();
    end
    chk("rs_pre_valid", 64'(o_valid[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_valid", 64'(o_valid[0]), 64'd0);
    chk("rs_async_data", o_data[0], 64'd0);
    chk("rs_async_tag", 64'(o_tag[0]), 64'd0);
    s_valid[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs_in_ready", 64'(i_ready[0]), 64'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rs_quiet%0d", c), 64'(o_valid[0]), 64'd0);
    end
    for (int g = 0; g < N; g++) begin
      w = cw(g);
      q.delete();
      held = 1'b0;
      sd = '0; sc = 1'b0; st = '0;
      for (int c = 0; c < 400; c++) begin
        set_beat(g, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 2 * w + 1)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)), 6'(c));
        s_valid[g]  = (c < 370) && ($urandom_range(0, 3) != 0);
        s_oready[g] = (c >= 370) || ($urandom_range(0, 9) < 7);
        @(negedge clk);
        if (held) begin
          chk($sformatf("sw%0d_hold_valid", g), 64'(o_valid[g]), 64'd1);
          chk($sformatf("sw%0d_hold_data", g), o_data[g], sd);
          chk($sformatf("sw%0d_hold_carry", g), 64'(o_carry[g]), 64'(sc));
          chk($sformatf("sw%0d_hold_tag", g), 64'(o_tag[g]), 64'(st));
        end
        if (o_valid[g] && s_oready[g]) begin
          chk($sformatf("sw%0d_expected_beat", g), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("sw%0d_data", g), o_data[g], e.d);
            chk($sformatf("sw%0d_carry", g), 64'(o_carry[g]), 64'(e.c));
            chk($sformatf("sw%0d_tag", g), 64'(o_tag[g]), 64'(e.t));
          end
        end
        if (s_valid[g] && i_ready[g]) begin
          m = ref_shift(w, s_op[g], s_imm[g], s_amt[g], s_data[g], s_cin[g]);
          q.push_back('{m[63:0], m[64], s_tag[g]});
        end
        held = o_valid[g] && !s_oready[g];
        sd = o_data[g];
        sc = o_carry[g];
        st = o_tag[g];
        tick();
      end
      chk($sformatf("sw%0d_drained", g), 64'(q.size()), 64'd0);
      idle_all();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
